uart_rx_axis_fifo: RTL and testbench
====================================

Name: uart_rx_axis_fifo

Overview:
Receive-side buffer placed directly downstream of the UART RX-to-AXI-Stream stage. That stage emits one byte per s_tvalid pulse with an error flag on tuser and cannot be stalled. This block absorbs those bytes into a first-word-fall-through FIFO and presents them on an AXI-Stream master with full tready backpressure. It also drops or tags errored bytes and reports overflow.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..256
AW, $clog2(DEPTH), pointer index width (derived, not overridden)
DROP_ERRORED, 1, 1 = bytes with s_tuser=1 are discarded; 0 = stored and forwarded with m_tuser=1

Ports:
aclk  input  1  clock; all logic on rising edge
areset  input  1  synchronous, active-high reset
s_tdata  input  8  received byte from UART RX stage
s_tuser  input  1  byte error flag (parity/stop), qualified by s_tvalid
s_tvalid  input  1  single-cycle byte strobe; no s_tready exists
m_tdata  output  8  head byte of FIFO
m_tuser  output  1  error flag of head byte
m_tvalid  output  1  FIFO not empty
m_tready  input  1  downstream accept
fill_level  output  AW+1  current number of stored entries, 0..DEPTH
overflow  output  1  sticky: a valid byte was lost because the FIFO was full
overflow_clr  input  1  single-cycle clear of overflow
err_count  output  16  errored bytes seen (see Optional Feature)
drop_count  output  16  bytes lost to overflow (see Optional Feature)

Behaviour:
- Reset: areset=1 at a rising edge clears pointers, fill_level=0, m_tvalid=0, overflow=0, err_count=0, drop_count=0. m_tdata/m_tuser are don't-care while m_tvalid=0.
- Reset mid-operation flushes all stored data. No stale byte appears after reset.
- Storage: DEPTH x 9-bit register array {tuser,tdata}. Read and write pointers are AW+1 bits wide and wrap modulo 2*DEPTH. empty = pointers equal. full = MSBs differ and low AW bits equal.
- m_tdata/m_tuser = mem[rd_ptr[AW-1:0]], driven combinationally (FWFT). m_tvalid = !empty.
- pop = m_tvalid && m_tready. rd_ptr increments on pop.
- accept = s_tvalid && !(s_tuser && DROP_ERRORED). push = accept && (!full || pop). On push, write {s_tuser,s_tdata} at wr_ptr, then wr_ptr increments.
- Full plus simultaneous pop: the incoming byte is pushed; fill_level stays DEPTH.
- Empty plus simultaneous write: no bypass. m_tvalid rises one cycle after s_tvalid (latency 1 cycle).
- fill_level: +1 on push only, -1 on pop only, unchanged on both or neither. Registered.
- Overflow: accept && full && !pop means the byte is dropped and overflow is set. overflow_clr clears it. If a set and a clear occur in the same cycle, set wins.
- Discarded errored bytes (DROP_ERRORED=1) never touch pointers or overflow.
- m_tvalid and m_tdata stay stable until pop (AXI-Stream rule), regardless of writes.

Optional Feature:
Macro UART_RX_FIFO_STATS_EN.
- Defined:
  - err_count increments on every s_tvalid && s_tuser, whether the byte is stored or dropped.
  - drop_count increments on every overflow drop.
  - Both counters saturate at 16'hFFFF and clear only on areset.
- Not defined: err_count and drop_count are tied to 0 and no counter flops are synthesized. overflow is unaffected either way.

Test Plan:
- Reset then write 0x41,0x42,0x43 with m_tready=1 -> m_tvalid rises 1 cycle after first s_tvalid; outputs 0x41,0x42,0x43 in order; fill_level returns to 0.
- DEPTH=16, m_tready=0, write 17 bytes 0x00..0x10 -> fill_level=16, overflow=1, drop_count=1 (STATS_EN); draining yields 0x00..0x0F, and 0x10 is absent.
- FIFO full, s_tvalid with 0xA5 in the same cycle as pop -> no overflow, fill_level stays 16, 0xA5 is output last.
- DROP_ERRORED=1: write 0x11, 0x22 (tuser=1), 0x33 -> output 0x11,0x33, err_count=1. DROP_ERRORED=0: same stimulus -> 0x22 output with m_tuser=1.
- m_tready toggled 1,0,1 with 8 bytes stored -> m_tdata held while m_tready=0; 8 unique pops, no duplicates; fill_level decrements only on pop.
- areset asserted with 5 bytes stored, then released -> m_tvalid=0, fill_level=0, overflow=0; the next write 0x7E is the first byte out.

Source files
------------

// File: rtl/uart_rx_axis_fifo.sv
// FWFT receive FIFO between a non-stallable UART RX byte stream and an AXI-Stream master.
// Optional statistics counters (err_count, drop_count) are built when UART_RX_FIFO_STATS_EN is defined.
module uart_rx_axis_fifo #(
    parameter int DEPTH        = 16,
    parameter int DROP_ERRORED = 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [7:0]               s_tdata,
    input  logic                     s_tuser,
    input  logic                     s_tvalid,
    output logic [7:0]               m_tdata,
    output logic                     m_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [15:0]              err_count,
    output logic [15:0]              drop_count
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        accept;
    logic        push;
    logic        ovf_drop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign m_tvalid = !empty;
    assign {m_tuser, m_tdata} = mem[rd_ptr[AW-1:0]];

    assign pop      = m_tvalid && m_tready;
    assign accept   = s_tvalid && !(s_tuser && (DROP_ERRORED != 0));
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push     = accept && (!full || pop);
    assign ovf_drop = accept && full && !pop;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_tuser, s_tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fill_level <= fill_level + 1'b1;
            end else if (pop && !push) begin
                fill_level <= fill_level - 1'b1;
            end
            // Set has priority over a coincident clear.
            if (ovf_drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (s_tvalid && s_tuser && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (ovf_drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`else
    assign err_count  = 16'd0;
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Directed self-checking bench for uart_rx_axis_fifo; one instance drops errored bytes, the other tags them.
module tb_uart_rx_axis_fifo;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tuser = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        m_tready = 1'b0;
    logic        overflow_clr = 1'b0;

    logic [7:0]  m_tdata,  m_tdata0;
    logic        m_tuser,  m_tuser0;
    logic        m_tvalid, m_tvalid0;
    logic [4:0]  fill_level, fill_level0;
    logic        overflow, overflow0;
    logic [15:0] err_count, err_count0;
    logic [15:0] drop_count, drop_count0;

    int passed = 0;
    int total  = 0;

`ifdef UART_RX_FIFO_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    uart_rx_axis_fifo #(.DEPTH(16), .DROP_ERRORED(1)) dut (
        .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .fill_level(fill_level), .overflow(overflow), .overflow_clr(overflow_clr),
        .err_count(err_count), .drop_count(drop_count)
    );

    uart_rx_axis_fifo #(.DEPTH(16), .DROP_ERRORED(0)) dut0 (
        .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
        .m_tdata(m_tdata0), .m_tuser(m_tuser0), .m_tvalid(m_tvalid0), .m_tready(m_tready),
        .fill_level(fill_level0), .overflow(overflow0), .overflow_clr(overflow_clr),
        .err_count(err_count0), .drop_count(drop_count0)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic u);
        s_tdata  = d;
        s_tuser  = u;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid got %0b want 0", m_tvalid); else passed++;
        total++; if (fill_level !== 5'd0) $display("FAIL reset_fill got %0d want 0", fill_level); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else passed++;
        total++; if (err_count !== 16'd0) $display("FAIL reset_err got %0d want 0", err_count); else passed++;
        total++; if (drop_count !== 16'd0) $display("FAIL reset_drop got %0d want 0", drop_count); else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        logic [7:0] exp_b;
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata  = 8'h41 + 8'(i);
            s_tvalid = 1'b1;
            if (i == 0) begin
                total++; if (m_tvalid !== 1'b0) $display("FAIL basic_latency got %0b want 0", m_tvalid); else passed++;
            end
            tick();
            if (i == 0) begin
                total++; if (m_tvalid !== 1'b1) $display("FAIL basic_tvalid_rise got %0b want 1", m_tvalid); else passed++;
            end
            if (m_tvalid) q.push_back(m_tdata);
        end
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_tvalid) q.push_back(m_tdata);
        end
        total++; if (q.size() != 3) $display("FAIL basic_count got %0d want 3", q.size()); else passed++;
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            exp_b = 8'h41 + 8'(i);
            total++; if (q[i] !== exp_b) $display("FAIL basic_data%0d got %h want %h", i, q[i], exp_b); else passed++;
        end
        total++; if (fill_level !== 5'd0) $display("FAIL basic_fill got %0d want 0", fill_level); else passed++;
        m_tready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        logic [7:0] exp_b;
        int guard;
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 17; i++) wr(8'(i), 1'b0);
        total++; if (fill_level !== 5'd16) $display("FAIL ovf_fill got %0d want 16", fill_level); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else passed++;
        total++; if (drop_count !== 16'(STATS)) $display("FAIL ovf_drop got %0d want %0d", drop_count, STATS); else passed++;
        // Drop and clear in the same cycle: overflow must stay set.
        overflow_clr = 1'b1;
        wr(8'hEE, 1'b0);
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %0b want 1", overflow); else passed++;
        total++; if (drop_count !== 16'(2 * STATS)) $display("FAIL ovf_drop2 got %0d want %0d", drop_count, 2 * STATS); else passed++;
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %0b want 0", overflow); else passed++;
        total++; if (m_tdata !== 8'h00) $display("FAIL full_head got %h want 00", m_tdata); else passed++;
        m_tready = 1'b1;
        wr(8'hA5, 1'b0);
        m_tready = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow got %0b want 0", overflow); else passed++;
        total++; if (fill_level !== 5'd16) $display("FAIL fullpop_fill got %0d want 16", fill_level); else passed++;
        m_tready = 1'b1;
        guard = 0;
        while (m_tvalid && guard < 40) begin
            q.push_back(m_tdata);
            tick();
            guard++;
        end
        m_tready = 1'b0;
        total++; if (q.size() != 16) $display("FAIL drain_count got %0d want 16", q.size()); else passed++;
        for (int i = 0; i < 16 && i < q.size(); i++) begin
            exp_b = (i == 15) ? 8'hA5 : 8'(i + 1);
            total++; if (q[i] !== exp_b) $display("FAIL drain_data%0d got %h want %h", i, q[i], exp_b); else passed++;
        end
    endtask

    task automatic test_errored();
        logic [7:0] q1[$];
        logic [8:0] q0[$];
        int guard;
        do_reset();
        m_tready = 1'b0;
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b1);
        wr(8'h33, 1'b0);
        total++; if (fill_level !== 5'd2) $display("FAIL err_fill_drop got %0d want 2", fill_level); else passed++;
        total++; if (fill_level0 !== 5'd3) $display("FAIL err_fill_tag got %0d want 3", fill_level0); else passed++;
        total++; if (err_count !== 16'(STATS)) $display("FAIL err_count got %0d want %0d", err_count, STATS); else passed++;
        m_tready = 1'b1;
        guard = 0;
        while ((m_tvalid || m_tvalid0) && guard < 20) begin
            if (m_tvalid) q1.push_back(m_tdata);
            if (m_tvalid0) q0.push_back({m_tuser0, m_tdata0});
            tick();
            guard++;
        end
        m_tready = 1'b0;
        total++; if (q1.size() != 2) $display("FAIL err_drop_count got %0d want 2", q1.size());
        else if (q1[0] !== 8'h11 || q1[1] !== 8'h33) $display("FAIL err_drop_data got %h %h want 11 33", q1[0], q1[1]);
        else passed++;
        total++; if (q0.size() != 3) $display("FAIL err_tag_count got %0d want 3", q0.size());
        else if (q0[0] !== 9'h011 || q0[1] !== 9'h122 || q0[2] !== 9'h033)
            $display("FAIL err_tag_data got %h %h %h want 011 122 033", q0[0], q0[1], q0[2]);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        logic [7:0] head;
        logic [4:0] exp_fill;
        int cyc;
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), 1'b0);
        exp_fill = 5'd8;
        cyc = 0;
        while (q.size() < 8 && cyc < 40) begin
            m_tready = (cyc % 3 != 1);
            head = m_tdata;
            if (m_tready && m_tvalid) begin
                q.push_back(head);
                exp_fill = exp_fill - 5'd1;
            end
            tick();
            if (!m_tready) begin
                total++; if (m_tdata !== head) $display("FAIL hold_data got %h want %h", m_tdata, head); else passed++;
            end
            total++; if (fill_level !== exp_fill) $display("FAIL bp_fill got %0d want %0d", fill_level, exp_fill); else passed++;
            cyc++;
        end
        m_tready = 1'b0;
        total++; if (q.size() != 8) $display("FAIL bp_count got %0d want 8", q.size()); else passed++;
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            total++; if (q[i] !== 8'h80 + 8'(i)) $display("FAIL bp_data%0d got %h want %h", i, q[i], 8'h80 + 8'(i)); else passed++;
        end
    endtask

    task automatic test_midreset();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i), 1'b0);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        total++; if (m_tvalid !== 1'b0) $display("FAIL mrst_tvalid got %0b want 0", m_tvalid); else passed++;
        total++; if (fill_level !== 5'd0) $display("FAIL mrst_fill got %0d want 0", fill_level); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL mrst_overflow got %0b want 0", overflow); else passed++;
        wr(8'h7E, 1'b0);
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h7E) $display("FAIL mrst_first got v=%0b %h want v=1 7e", m_tvalid, m_tdata); else passed++;
        total++; if (fill_level !== 5'd1) $display("FAIL mrst_fill1 got %0d want 1", fill_level); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_errored();
        test_backpressure();
        test_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
